// File: rtl/nibble_serial_adder16_pkg.sv
// nibble_serial_adder16_pkg: shared FSM encoding and nibble width for serial stages
package nibble_serial_adder16_pkg;
  localparam int NIBBLE_W = 4;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
endpackage

// File: rtl/nibble_serial_adder16_if.sv
// nibble_serial_adder16_if: operand/result handshake bundle
interface nibble_serial_adder16_if #(parameter int WIDTH = 16);
  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  modport master (output InValid, A, B, Cin, OutReady, input InReady, OutValid, Sum, Cout);
  modport slave  (input InValid, A, B, Cin, OutReady, output InReady, OutValid, Sum, Cout);
endinterface

// File: rtl/nibble_serial_adder16_add4.sv
// SerialAdder4bits: 4-bit adder with carry in/out, one nibble per cycle
module SerialAdder4bits (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + 5'(c_i);
endmodule

// File: rtl/nibble_serial_adder16.sv
// nibble_serial_adder16: adds A+B+Cin one nibble per cycle through a single 4-bit adder
module nibble_serial_adder16
  import nibble_serial_adder16_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic clk,
  input logic rst,
  nibble_serial_adder16_if.slave io
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);
  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             cout_q;
  logic [3:0]       a_nib, b_nib, s_nib;
  logic             c_nib;
  logic             accept, last;
  assign accept = (state_q == IDLE) && io.InValid;
  assign last   = idx_q == LAST;
  // pick the current nibble of each captured operand
  always_comb begin
    a_nib = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
    b_nib = b_q[NIBBLE_W*idx_q +: NIBBLE_W];
  end
  SerialAdder4bits u_add (
    .a_i(a_nib),
    .b_i(b_nib),
    .c_i(carry_q),
    .s_o(s_nib),
    .c_o(c_nib)
  );
  // next state: IDLE->RUN on accept, RUN->DONE on last nibble, DONE->IDLE on handshake
  always_comb begin
    state_d = state_q;
    state_d = accept ? RUN
            : (state_q == RUN && last) ? DONE
            : (state_q == DONE && io.OutReady) ? IDLE
            : state_q;
  end
  // datapath and state registers; reset overrides any handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q     <= io.A;
        b_q     <= io.B;
        carry_q <= io.Cin;
        idx_q   <= '0;
      end else if (state_q == RUN) begin
        sum_q[NIBBLE_W*idx_q +: NIBBLE_W] <= s_nib;
        carry_q <= c_nib;
        idx_q   <= last ? idx_q : idx_q + IW'(1);
        if (last) cout_q <= c_nib;
      end
    end
  end
  assign io.InReady  = state_q == IDLE;
  assign io.OutValid = state_q == DONE;
  assign io.Sum      = sum_q;
  assign io.Cout     = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder16.sv
// tb_nibble_serial_adder16: directed self-checking bench for the nibble-serial adder
module tb_nibble_serial_adder16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int n;
  nibble_serial_adder16_if #(.WIDTH(16)) bus ();
  nibble_serial_adder16 #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .io(bus.slave));
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_out(input string tag);
    n = 0;
    while (!bus.OutValid && n < 12) begin
      step();
      n++;
    end
    check({tag, "_latency"}, n, 4);
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic [15:0] s, input logic co);
    check({tag, "_inready"}, bus.InReady, 1'b1);
    bus.A = a; bus.B = b; bus.Cin = cin; bus.InValid = 1'b1;
    step();
    bus.InValid = 1'b0;
    wait_out(tag);
    check({tag, "_sum"}, bus.Sum, s);
    check({tag, "_cout"}, bus.Cout, co);
    bus.OutReady = 1'b1;
    step();
    bus.OutReady = 1'b0;
    check({tag, "_idle_ready"}, bus.InReady, 1'b1);
    check({tag, "_idle_valid"}, bus.OutValid, 1'b0);
    check({tag, "_idle_sum_hold"}, bus.Sum, s);
    step();
  endtask

  initial begin
    bus.InValid = 1'b0; bus.OutReady = 1'b0; bus.A = '0; bus.B = '0; bus.Cin = 1'b0;
    step(); step();
    rst = 1'b0;
    check("rst_inready", bus.InReady, 1'b1);
    check("rst_outvalid", bus.OutValid, 1'b0);
    check("rst_sum", bus.Sum, 16'h0000);
    check("rst_cout", bus.Cout, 1'b0);

    run_op("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    run_op("cin_ripple", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
    run_op("msb_carry", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
    run_op("mixed", 16'hA5C3, 16'h5A3D, 1'b1, 16'h0001, 1'b1);

    // backpressure and ignored inputs while busy
    bus.A = 16'h1111; bus.B = 16'h2222; bus.Cin = 1'b0; bus.InValid = 1'b1;
    step();
    bus.InValid = 1'b0;
    bus.OutReady = 1'b1;
    bus.A = 16'hAAAA; bus.B = 16'hBBBB; bus.Cin = 1'b1;
    step();
    check("bp_run_inready", bus.InReady, 1'b0);
    bus.InValid = 1'b1;
    step();
    bus.InValid = 1'b0;
    bus.OutReady = 1'b0;
    step(); step();
    check("bp_done_valid", bus.OutValid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      bus.InValid = i[0];
      check("bp_hold_sum", bus.Sum, 16'h3333);
      check("bp_hold_cout", bus.Cout, 1'b0);
      check("bp_hold_valid", bus.OutValid, 1'b1);
      check("bp_hold_inready", bus.InReady, 1'b0);
      step();
    end
    bus.InValid = 1'b0;
    check("bp_final_sum", bus.Sum, 16'h3333);
    bus.OutReady = 1'b1;
    step();
    bus.OutReady = 1'b0;
    check("bp_release_idle", bus.InReady, 1'b1);
    step();
    check("bp_stays_idle", bus.InReady, 1'b1);

    // reset two cycles after accept discards the operation
    bus.A = 16'h0F0F; bus.B = 16'h0101; bus.Cin = 1'b0; bus.InValid = 1'b1;
    step();
    bus.InValid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_sum", bus.Sum, 16'h0000);
    check("mid_rst_cout", bus.Cout, 1'b0);
    check("mid_rst_valid", bus.OutValid, 1'b0);
    check("mid_rst_ready", bus.InReady, 1'b1);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.OutValid) n++;
      step();
    end
    check("mid_rst_no_pulse", n, 0);
    run_op("after_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0);

    // back-to-back with InValid and OutReady held high
    bus.A = 16'h0102; bus.B = 16'h0304; bus.Cin = 1'b0;
    bus.InValid = 1'b1; bus.OutReady = 1'b1;
    step();
    n = 0;
    while (!bus.InReady && n < 12) begin
      if (bus.OutValid) check("b2b_first_sum", bus.Sum, 16'h0406);
      step();
      n++;
    end
    check("b2b_first_handshake", n, 5);
    bus.A = 16'hFFFF; bus.B = 16'h0001;
    step();
    n++;
    check("b2b_accept_spacing", n, 6);
    check("b2b_second_busy", bus.InReady, 1'b0);
    bus.InValid = 1'b0;
    bus.OutReady = 1'b0;
    wait_out("b2b_second");
    check("b2b_second_sum", bus.Sum, 16'h0000);
    check("b2b_second_cout", bus.Cout, 1'b1);
    bus.OutReady = 1'b1;
    step();
    bus.OutReady = 1'b0;
    check("b2b_end_idle", bus.InReady, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
